// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback path: widths, special
// register indices and writeback requester indices.
package regfile_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned NREG    = 2 ** ADDR_W;

  localparam logic [3:0] REG_PC = 4'd15;
  localparam logic [3:0] REG_LR = 4'd14;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_LINK = 2;

  // Index width for a pool of n requesters (at least one bit).
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bus: NUM_REQ requesters, each with valid/dest/data, and
// one ready (grant) bit per requester back from the scheduler.
//   master : writeback source side (drives valid/dest/data, sees ready)
//   slave  : scheduler side
interface regfile_wb_scheduler_if #(
  parameter int unsigned NUM_REQ = regfile_pkg::NUM_REQ,
  parameter int unsigned DATA_W  = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W  = regfile_pkg::ADDR_W
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_dest;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;

  modport master (output req_valid, req_dest, req_data, input req_ready);
  modport slave  (input req_valid, req_dest, req_data, output req_ready);

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter. Searches req starting at ptr and grants the first
// set index; hold suppresses all grants.
//   req       : request vector
//   hold      : 1 = grant nothing
//   ptr       : search start index (0..NUM_REQ-1)
//   grant     : one-hot grant (combinational)
//   grant_idx : index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = regfile_pkg::idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Rotating priority search; the first hit from ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!hold && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the single register-file write port between the ALU, load and link
// writeback sources, and keeps a per-register busy scoreboard for RAW stalls.
//   clk, reset     : clock, async active-low reset
//   wbIf           : writeback request bus (valid/dest/data in, ready out)
//   wb_hold        : suppress grants this cycle
//   alloc_valid/alloc_dest : decode reserves a destination register
//   busy           : scoreboard, bit d = write to Rd pending
//   alloc_conflict : pulse, the previous alloc hit an already-busy register
//   rf_write_*     : registered register-file write port
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = regfile_pkg::NUM_REQ,
  parameter int unsigned DATA_W  = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  regfile_wb_scheduler_if.slave      wbIf,
  input  logic                       wb_hold,
  input  logic                       alloc_valid,
  input  logic [ADDR_W-1:0]          alloc_dest,
  output logic [(2**ADDR_W)-1:0]     busy,
  output logic                       alloc_conflict,
  output logic                       rf_write_en,
  output logic [ADDR_W-1:0]          rf_write_dest,
  output logic [DATA_W-1:0]          rf_write_data,
  output logic                       rf_write_pc
);

  localparam int unsigned PTR_W   = idxWidth(NUM_REQ);
  localparam int unsigned NREG_L  = 2 ** ADDR_W;

  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   grantIdx;
  logic [NUM_REQ-1:0] grant;
  logic               grantAny;
  logic [ADDR_W-1:0]  grantDest;
  logic [NREG_L-1:0]  busyNext;
  logic               conflictNext;

  // Holding the arbiter while reset is low keeps every ready low in reset.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) uArb (
    .req       (wbIf.req_valid),
    .hold      (wb_hold | ~reset),
    .ptr       (rrPtr),
    .grant     (grant),
    .grant_idx (grantIdx)
  );

  assign wbIf.req_ready = grant;
  assign grantAny       = |grant;
  assign grantDest      = wbIf.req_dest[grantIdx];

  // Write port and round-robin pointer: a grant at this edge becomes the
  // register-file write during the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_en   <= 1'b0;
      rf_write_dest <= '0;
      rf_write_data <= '0;
      rf_write_pc   <= 1'b0;
      rrPtr         <= '0;
    end else begin
      rf_write_en <= grantAny;
      rf_write_pc <= grantAny && (grantDest == ADDR_W'(REG_PC));
      if (grantAny) begin
        rf_write_dest <= grantDest;
        rf_write_data <= wbIf.req_data[grantIdx];
        rrPtr         <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      end
    end
  end

  // Scoreboard: clear on the committing write, then set on alloc so a new
  // producer of the same register wins over the retiring one.
  always_comb begin
    busyNext = busy;
    if (rf_write_en) begin
      busyNext[rf_write_dest] = 1'b0;
    end
    if (alloc_valid) begin
      busyNext[alloc_dest] = 1'b1;
    end
    conflictNext = alloc_valid && busy[alloc_dest] &&
                   !(rf_write_en && (rf_write_dest == alloc_dest));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy           <= '0;
      alloc_conflict <= 1'b0;
    end else begin
      busy           <= busyNext;
      alloc_conflict <= conflictNext;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a vector table for arbitration order,
// directed sequences for the multi-cycle corners, and a randomized run
// against a transaction-level reference model.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  localparam int unsigned NR = NUM_REQ;
  localparam int unsigned PW = idxWidth(NR);
  localparam int          NRI = NR;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.NUM_REQ(NR), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wbIf ();

  logic               wb_hold;
  logic               alloc_valid;
  logic [ADDR_W-1:0]  alloc_dest;
  logic [NREG-1:0]    busy;
  logic               alloc_conflict;
  logic               rf_write_en;
  logic [ADDR_W-1:0]  rf_write_dest;
  logic [DATA_W-1:0]  rf_write_data;
  logic               rf_write_pc;

  regfile_wb_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .wbIf           (wbIf),
    .wb_hold        (wb_hold),
    .alloc_valid    (alloc_valid),
    .alloc_dest     (alloc_dest),
    .busy           (busy),
    .alloc_conflict (alloc_conflict),
    .rf_write_en    (rf_write_en),
    .rf_write_dest  (rf_write_dest),
    .rf_write_data  (rf_write_data),
    .rf_write_pc    (rf_write_pc)
  );

  int nVec = 0;
  int nMis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer, scoreboard, last committed write.
  int                mPtr;
  logic [NREG-1:0]   mBusy;
  logic              mWrEn;
  logic [ADDR_W-1:0] mDest;
  logic [DATA_W-1:0] mData;
  logic              mConf;

  task automatic modelReset();
    mPtr = 0; mBusy = '0; mWrEn = 1'b0; mDest = '0; mData = '0; mConf = 1'b0;
  endtask

  function automatic int pickGrant(input logic [NR-1:0] v, input logic hold, input int ptr);
    if (hold) return -1;
    for (int k = 0; k < NRI; k++) begin
      automatic int idx = (ptr + k) % NRI;
      if (v[PW'(idx)]) return idx;
    end
    return -1;
  endfunction

  // One clock: check the grant, advance the model, check registered outputs.
  task automatic tick(output int g);
    logic [NR-1:0]   expReady;
    logic [NREG-1:0] nBusy;
    #1;
    g = pickGrant(wbIf.req_valid, wb_hold, mPtr);
    expReady = '0;
    if (g >= 0) expReady[PW'(g)] = 1'b1;
    check("req_ready", 64'(wbIf.req_ready), 64'(expReady));
    nBusy = mBusy;
    if (mWrEn) nBusy[mDest] = 1'b0;
    if (alloc_valid) nBusy[alloc_dest] = 1'b1;
    mConf = alloc_valid && mBusy[alloc_dest] && !(mWrEn && mDest == alloc_dest);
    mBusy = nBusy;
    if (g >= 0) begin
      mWrEn = 1'b1;
      mDest = wbIf.req_dest[PW'(g)];
      mData = wbIf.req_data[PW'(g)];
      mPtr  = (g + 1) % NRI;
    end else begin
      mWrEn = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rf_write_en", 64'(rf_write_en), 64'(mWrEn));
    if (mWrEn) begin
      check("rf_write_dest", 64'(rf_write_dest), 64'(mDest));
      check("rf_write_data", 64'(rf_write_data), 64'(mData));
    end
    check("rf_write_pc", 64'(rf_write_pc), 64'(mWrEn && mDest == REG_PC));
    check("busy", 64'(busy), 64'(mBusy));
    check("alloc_conflict", 64'(alloc_conflict), 64'(mConf));
  endtask

  task automatic setReq(input int i, input logic v, input logic [ADDR_W-1:0] d,
                        input logic [DATA_W-1:0] x);
    wbIf.req_valid[PW'(i)] = v;
    wbIf.req_dest[PW'(i)]  = d;
    wbIf.req_data[PW'(i)]  = x;
  endtask

  task automatic doReset();
    reset = 1'b0;
    wbIf.req_valid = '0;
    wb_hold = 1'b0;
    alloc_valid = 1'b0;
    alloc_dest = '0;
    #1;
    check("reset_ready", 64'(wbIf.req_ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wr_en", 64'(rf_write_en), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    modelReset();
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic          hold;
    logic [NR-1:0] expReady;
  } vec_t;

  vec_t vt[8];
  logic [NR-1:0] rrSeq[3];

  initial begin
    int g;
    logic [ADDR_W-1:0] fixDest[3];
    logic [DATA_W-1:0] fixData[3];

    fixDest = '{4'd3, 4'd2, REG_LR};
    fixData = '{32'hAAAAAAAA, 32'h55555555, 32'h12345678};
    wbIf.req_dest = '0;
    wbIf.req_data = '0;
    doReset();

    // Arbitration order vectors, pointer starting at 0 after reset.
    vt[0] = '{3'b001, 1'b0, 3'b001};
    vt[1] = '{3'b111, 1'b0, 3'b010};
    vt[2] = '{3'b111, 1'b1, 3'b000};
    vt[3] = '{3'b011, 1'b0, 3'b001};
    vt[4] = '{3'b101, 1'b0, 3'b100};
    vt[5] = '{3'b000, 1'b0, 3'b000};
    vt[6] = '{3'b110, 1'b0, 3'b010};
    vt[7] = '{3'b001, 1'b0, 3'b001};
    for (int i = 0; i < 3; i++) setReq(i, 1'b0, fixDest[i], fixData[i]);
    for (int v = 0; v < 8; v++) begin
      wbIf.req_valid = vt[v].valid;
      wb_hold = vt[v].hold;
      #1;
      check("vec_ready", 64'(wbIf.req_ready), 64'(vt[v].expReady));
      tick(g);
      check("vec_wr_en", 64'(rf_write_en), 64'(vt[v].expReady != '0));
      if (v == 0) begin
        check("t1_dest", 64'(rf_write_dest), 64'd3);
        check("t1_data", 64'(rf_write_data), 64'hAAAAAAAA);
        check("t1_pc", 64'(rf_write_pc), 64'd0);
      end
    end
    wbIf.req_valid = '0;
    wb_hold = 1'b0;

    // All three requesters continuously valid: 0,1,2,0,... one write per cycle.
    doReset();
    rrSeq = '{3'b001, 3'b010, 3'b100};
    setReq(REQ_ALU, 1'b1, 4'd1, $urandom);
    setReq(REQ_LOAD, 1'b1, 4'd2, $urandom);
    setReq(REQ_LINK, 1'b1, 4'd14, $urandom);
    for (int c = 0; c < 7; c++) begin
      #1;
      check("rr_ready", 64'(wbIf.req_ready), 64'(rrSeq[c % 3]));
      tick(g);
      check("rr_wr_en", 64'(rf_write_en), 64'd1);
      if (g >= 0) wbIf.req_data[PW'(g)] = $urandom;
    end

    // Hold for 3 cycles with ALU+load pending; pointer sits at 1.
    wbIf.req_valid = 3'b011;
    wb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_ready", 64'(wbIf.req_ready), 64'd0);
      tick(g);
      check("hold_wr_en", 64'(rf_write_en), 64'd0);
    end
    wb_hold = 1'b0;
    #1;
    check("release_ready", 64'(wbIf.req_ready), 64'b010);
    tick(g);
    wbIf.req_valid = '0;
    tick(g);

    // Scoreboard set / clear / set-wins-over-clear.
    alloc_valid = 1'b1; alloc_dest = 4'd5;
    tick(g);
    check("sb_set5", 64'(busy[5]), 64'd1);
    alloc_valid = 1'b0;
    setReq(REQ_ALU, 1'b1, 4'd5, 32'h0000_0555);
    tick(g);
    check("sb_busy_during_write", 64'(busy[5]), 64'd1);
    wbIf.req_valid = '0;
    tick(g);
    check("sb_clear5", 64'(busy[5]), 64'd0);
    alloc_valid = 1'b1;
    tick(g);
    alloc_valid = 1'b0;
    setReq(REQ_ALU, 1'b1, 4'd5, 32'h0000_0556);
    tick(g);
    wbIf.req_valid = '0;
    alloc_valid = 1'b1;
    tick(g);
    check("sb_set_wins", 64'(busy[5]), 64'd1);
    check("sb_no_conflict_on_clear", 64'(alloc_conflict), 64'd0);
    alloc_valid = 1'b0;

    // Double alloc of R7 pulses alloc_conflict for one cycle.
    alloc_valid = 1'b1; alloc_dest = 4'd7;
    tick(g);
    check("conf_first", 64'(alloc_conflict), 64'd0);
    tick(g);
    check("conf_second", 64'(alloc_conflict), 64'd1);
    alloc_valid = 1'b0;
    tick(g);
    check("conf_pulse_end", 64'(alloc_conflict), 64'd0);

    // Link write to R15 drives the PC path.
    setReq(REQ_LINK, 1'b1, REG_PC, 32'h0000_0040);
    tick(g);
    check("pc_wr_en", 64'(rf_write_en), 64'd1);
    check("pc_flag", 64'(rf_write_pc), 64'd1);
    check("pc_data", 64'(rf_write_data), 64'h40);
    wbIf.req_valid = '0;

    // Reset mid-stream with a write in flight and busy bits set.
    wbIf.req_valid = 3'b111;
    tick(g);
    reset = 1'b0;
    #1;
    check("midrst_wr_en", 64'(rf_write_en), 64'd0);
    check("midrst_pc", 64'(rf_write_pc), 64'd0);
    check("midrst_dest", 64'(rf_write_dest), 64'd0);
    check("midrst_data", 64'(rf_write_data), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_conf", 64'(alloc_conflict), 64'd0);
    check("midrst_ready", 64'(wbIf.req_ready), 64'd0);
    wbIf.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    modelReset();
    tick(g);
    check("post_rst_no_write", 64'(rf_write_en), 64'd0);

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NRI; i++) begin
        if (!wbIf.req_valid[PW'(i)] && $urandom_range(0, 1) == 1)
          setReq(i, 1'b1, ADDR_W'($urandom_range(0, NREG - 1)), $urandom);
      end
      wb_hold = ($urandom_range(0, 4) == 0);
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_dest = ADDR_W'($urandom_range(0, NREG - 1));
      tick(g);
      if (g >= 0) wbIf.req_valid[PW'(g)] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
